// File: rtl/apbslave_ws_if.sv
// APB4 bus bundle for apbslave_ws: master drives the request, slave drives the response.
interface apbslave_ws_if #(
   parameter int C_APB_ADDR_WIDTH = 12,
   parameter int C_APB_DATA_WIDTH = 32
) ();
   logic                            PSEL;
   logic                            PENABLE;
   logic [C_APB_ADDR_WIDTH-1:0]     PADDR;
   logic                            PWRITE;
   logic [C_APB_DATA_WIDTH-1:0]     PWDATA;
   logic [C_APB_DATA_WIDTH/8-1:0]   PWSTRB;
   logic [2:0]                      PPROT;
   logic                            PREADY;
   logic [C_APB_DATA_WIDTH-1:0]     PRDATA;
   logic                            PSLVERR;

   modport master (
      output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PWSTRB, PPROT,
      input  PREADY, PRDATA, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PWSTRB, PPROT,
      output PREADY, PRDATA, PSLVERR
   );
endinterface

// File: rtl/apbslave_ws.sv
// APB4 scratch-RAM slave with programmable read/write wait states, abort on PSEL drop and
// PSLVERR on out-of-range words. Define APBSLAVE_PRIV_EN to fault unprivileged access at/above PRIV_BASE.
//
// state  | meaning
// S_IDLE | waiting for a setup phase; live bus values steer the transfer
// S_WAIT | counting wait states on captured request; PSEL low aborts
// S_DONE | completing access cycle, PREADY high for exactly one cycle
module apbslave_ws #(
   parameter int C_APB_ADDR_WIDTH = 12,
   parameter int C_APB_DATA_WIDTH = 32,
   parameter int MEM_WORDS        = 256,
   parameter int OPT_RDWAIT       = 0,
   parameter int OPT_WRWAIT       = 1,
   parameter int OPT_LOWPOWER     = 0,
   parameter int PRIV_BASE        = 128
) (
   input  logic          PCLK,
   input  logic          PRESET,
   apbslave_ws_if.slave  s_apb
);
   localparam int AW     = C_APB_ADDR_WIDTH;
   localparam int DW     = C_APB_DATA_WIDTH;
   localparam int SW     = DW / 8;
   localparam int APBLSB = $clog2(DW) - 3;
   localparam int IW     = AW - APBLSB;
   localparam int MIW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nx;

   logic [IW-1:0]    r_idx;
   logic             r_write;
   logic             r_err;
   logic [DW-1:0]    r_wdata;
   logic [SW-1:0]    r_wstrb;
   logic [3:0]       r_wcnt;

   logic             r_pready;
   logic             r_pslverr;
   logic [DW-1:0]    r_prdata;

   logic [DW-1:0]    r_mem [MEM_WORDS];

   logic             w_setup;
   logic             w_in_idle;
   logic [IW-1:0]    w_live_idx;
   logic             w_live_err;
   logic [3:0]       w_load_cnt;

   logic [IW-1:0]    w_idx;
   logic             w_write;
   logic             w_err;
   logic [DW-1:0]    w_wdata;
   logic [SW-1:0]    w_wstrb;
   logic [DW-1:0]    w_rd_word;
   logic             w_enter_done;
   logic             w_commit;
   logic             w_unused;

   assign w_setup    = s_apb.PSEL && !s_apb.PENABLE;
   assign w_in_idle  = (r_state == S_IDLE);
   assign w_live_idx = s_apb.PADDR[AW-1:APBLSB];
   assign w_load_cnt = s_apb.PWRITE ? 4'(OPT_WRWAIT) : 4'(OPT_RDWAIT);

   always_comb begin
      w_live_err = (32'(w_live_idx) >= 32'(MEM_WORDS));
`ifdef APBSLAVE_PRIV_EN
      if ((32'(w_live_idx) >= 32'(PRIV_BASE)) && !s_apb.PPROT[0])
         w_live_err = 1'b1;
`endif
   end

`ifdef APBSLAVE_PRIV_EN
   assign w_unused = &{1'b0, s_apb.PADDR, s_apb.PPROT[2:1], w_idx};
`else
   assign w_unused = &{1'b0, s_apb.PADDR, s_apb.PPROT, w_idx};
`endif

   // A zero-wait transfer completes straight out of IDLE, before the capture registers are loaded
   assign w_idx   = w_in_idle ? w_live_idx    : r_idx;
   assign w_write = w_in_idle ? s_apb.PWRITE  : r_write;
   assign w_err   = w_in_idle ? w_live_err    : r_err;
   assign w_wdata = w_in_idle ? s_apb.PWDATA  : r_wdata;
   assign w_wstrb = w_in_idle ? s_apb.PWSTRB  : r_wstrb;

   assign w_rd_word    = r_mem[w_idx[MIW-1:0]];
   assign w_enter_done = (w_state_nx == S_DONE) && !PRESET;
   assign w_commit     = w_enter_done && w_write && !w_err;

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_setup)
               w_state_nx = (w_load_cnt == 4'd0) ? S_DONE : S_WAIT;
         end
         S_WAIT: begin
            if (!s_apb.PSEL)
               w_state_nx = S_IDLE;
            else if (r_wcnt == 4'd1)
               w_state_nx = S_DONE;
         end
         S_DONE: w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state   <= S_IDLE;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         r_prdata  <= '0;
         r_idx     <= '0;
         r_write   <= 1'b0;
         r_err     <= 1'b0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_wcnt    <= 4'd0;
      end else begin
         r_state   <= w_state_nx;
         r_pready  <= w_enter_done;
         r_pslverr <= w_enter_done && w_err;
         if (w_enter_done && !w_write)
            r_prdata <= w_err ? '0 : w_rd_word;
         if (w_in_idle && w_setup) begin
            r_idx   <= w_live_idx;
            r_write <= s_apb.PWRITE;
            r_err   <= w_live_err;
            r_wdata <= s_apb.PWDATA;
            r_wstrb <= s_apb.PWSTRB;
            r_wcnt  <= w_load_cnt;
         end else if ((r_state == S_WAIT) && s_apb.PSEL) begin
            r_wcnt  <= r_wcnt - 4'd1;
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (w_commit) begin
         for (int b = 0; b < SW; b++) begin
            if (w_wstrb[b])
               r_mem[w_idx[MIW-1:0]][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
   end

   assign s_apb.PREADY  = r_pready;
   assign s_apb.PSLVERR = r_pslverr;
   assign s_apb.PRDATA  = ((OPT_LOWPOWER != 0) && !r_pready) ? '0 : r_prdata;
endmodule

// File: tb/tb_apbslave_ws.sv
// Scoreboard bench for apbslave_ws: default-config DUT plus a long-wait, low-power DUT.
module tb_apbslave_ws;
   logic        PCLK = 1'b0;
   logic        PRESET = 1'b1;
   logic        psel, penable, pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pwstrb;
   logic [2:0]  pprot;
   int          bus;

   always #5 PCLK = ~PCLK;

   apbslave_ws_if #(.C_APB_ADDR_WIDTH(12), .C_APB_DATA_WIDTH(32)) if0 ();
   apbslave_ws_if #(.C_APB_ADDR_WIDTH(12), .C_APB_DATA_WIDTH(32)) if1 ();

   assign if0.PSEL = psel && (bus == 0);
   assign if1.PSEL = psel && (bus == 1);
   assign if0.PENABLE = penable;  assign if1.PENABLE = penable;
   assign if0.PADDR   = paddr;    assign if1.PADDR   = paddr;
   assign if0.PWRITE  = pwrite;   assign if1.PWRITE  = pwrite;
   assign if0.PWDATA  = pwdata;   assign if1.PWDATA  = pwdata;
   assign if0.PWSTRB  = pwstrb;   assign if1.PWSTRB  = pwstrb;
   assign if0.PPROT   = pprot;    assign if1.PPROT   = pprot;

   apbslave_ws u_dut0 (.PCLK(PCLK), .PRESET(PRESET), .s_apb(if0));
   apbslave_ws #(.OPT_RDWAIT(2), .OPT_WRWAIT(3), .OPT_LOWPOWER(1))
      u_dut1 (.PCLK(PCLK), .PRESET(PRESET), .s_apb(if1));

   typedef struct {
      logic [31:0] data;
      bit          err;
      bit          rd;
      int          lat;
      int          id;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;
   int   tests = 0;
   int   fails = 0;
   int   acc0 = 0, acc1 = 0, id_ctr = 0;

   task automatic check_rsp(input int b, input exp_t e, input logic [31:0] d,
                            input logic err, input int lat);
      tests++;
      if (err !== e.err || lat != e.lat || (e.rd && d !== e.data)) begin
         fails++;
         $display("FAIL rsp bus%0d id%0d: got data=%h err=%b lat=%0d, want data=%h err=%b lat=%0d",
                  b, e.id, d, err, lat, e.data, e.err, e.lat);
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h, want %h", nm, got, want);
      end
   endtask

   // Monitors: access-cycle count since setup is the observed latency
   always @(negedge PCLK) begin
      if (if0.PSEL && !if0.PENABLE) acc0 = 0;
      else if (if0.PSEL && if0.PENABLE) acc0++;
      if (if0.PREADY === 1'b1) begin
         if (q0.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_pready bus0: got PREADY=1 data=%h, want no response", if0.PRDATA);
         end else begin
            e0 = q0.pop_front();
            check_rsp(0, e0, if0.PRDATA, if0.PSLVERR, acc0);
         end
      end
   end

   always @(negedge PCLK) begin
      if (if1.PSEL && !if1.PENABLE) acc1 = 0;
      else if (if1.PSEL && if1.PENABLE) acc1++;
      if (if1.PREADY === 1'b1) begin
         if (q1.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_pready bus1: got PREADY=1 data=%h, want no response", if1.PRDATA);
         end else begin
            e1 = q1.pop_front();
            check_rsp(1, e1, if1.PRDATA, if1.PSLVERR, acc1);
         end
      end
   end

   task automatic push(input int b, input logic [31:0] d, input bit err, input bit rd, input int lat);
      exp_t e;
      e.data = d; e.err = err; e.rd = rd; e.lat = lat; e.id = id_ctr;
      id_ctr++;
      if (b == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic xfer(input int b, input bit wr, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p, input int abort_after);
      int n;
      bit rdy;
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      bus = b; psel = 1'b1; penable = 1'b0;
      pwrite = wr; paddr = a; pwdata = d; pwstrb = s; pprot = p;
      @(posedge PCLK); #1;
      penable = 1'b1;
      rdy = 1'b0;
      n = 0;
      while (!rdy && n < 40) begin
         @(negedge PCLK);
         n++;
         rdy = (b == 0) ? if0.PREADY : if1.PREADY;
         if (!rdy) begin
            if (n == abort_after) begin
               @(posedge PCLK); #1;
               psel = 1'b0; penable = 1'b0;
               return;
            end
            @(posedge PCLK); #1;
         end
      end
      if (!rdy) begin
         tests++; fails++;
         $display("FAIL timeout bus%0d addr=%h: got no PREADY, want PREADY within 40 cycles", b, a);
         psel = 1'b0; penable = 1'b0;
      end
   endtask

   task automatic wr(input int b, input logic [11:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [2:0] p, input bit err);
      push(b, 32'h0, err, 1'b0, (b == 0) ? 2 : 4);
      xfer(b, 1'b1, a, d, s, p, -1);
   endtask

   task automatic rd(input int b, input logic [11:0] a, input logic [2:0] p,
                     input logic [31:0] d, input bit err);
      push(b, d, err, 1'b1, (b == 0) ? 1 : 3);
      xfer(b, 1'b0, a, 32'h0, 4'h0, p, -1);
   endtask

   task automatic idle();
      @(posedge PCLK); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
      pwdata = '0; pwstrb = '0; pprot = 3'b001; bus = 0;
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      chk("rst_pready0",  {31'b0, if0.PREADY},  32'h0);
      chk("rst_pslverr0", {31'b0, if0.PSLVERR}, 32'h0);
      chk("rst_prdata0",  if0.PRDATA,           32'h0);
      chk("rst_pready1",  {31'b0, if1.PREADY},  32'h0);
      chk("rst_pslverr1", {31'b0, if1.PSLVERR}, 32'h0);
      chk("rst_prdata1",  if1.PRDATA,           32'h0);
      @(posedge PCLK); #1;
      PRESET = 1'b0;

      // default config: write waits 1, read waits 0
      wr(0, 12'h010, 32'h12345678, 4'hF, 3'b001, 1'b0);
      rd(0, 12'h010, 3'b001, 32'h12345678, 1'b0);
      wr(0, 12'h010, 32'hAABBCCDD, 4'b0101, 3'b001, 1'b0);
      rd(0, 12'h010, 3'b001, 32'h12BB56DD, 1'b0);
      rd(0, 12'h400, 3'b001, 32'h00000000, 1'b1);
      rd(0, 12'h010, 3'b001, 32'h12BB56DD, 1'b0);
      wr(0, 12'h3FC, 32'hCAFEF00D, 4'hF, 3'b001, 1'b0);
      rd(0, 12'h3FC, 3'b001, 32'hCAFEF00D, 1'b0);
      wr(0, 12'h000, 32'h01020304, 4'hF, 3'b001, 1'b0);
      wr(0, 12'h400, 32'hFFFFFFFF, 4'hF, 3'b001, 1'b1);
      rd(0, 12'h000, 3'b001, 32'h01020304, 1'b0);
      wr(0, 12'h010, 32'hFFFFFFFF, 4'h0, 3'b001, 1'b0);
      rd(0, 12'h010, 3'b001, 32'h12BB56DD, 1'b0);
      idle();
      @(negedge PCLK);
      chk("hold_prdata0",  if0.PRDATA,           32'h12BB56DD);
      chk("idle_pready0",  {31'b0, if0.PREADY},  32'h0);
      chk("idle_pslverr0", {31'b0, if0.PSLVERR}, 32'h0);

      // PENABLE without setup must be ignored
      @(posedge PCLK); #1;
      bus = 0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h010;
      pwdata = 32'h0; pwstrb = 4'hF;
      repeat (3) @(posedge PCLK);
      #1;
      psel = 1'b0; penable = 1'b0;
      rd(0, 12'h010, 3'b001, 32'h12BB56DD, 1'b0);

      // reset during write wait discards the write; setup follows reset release at once
      wr(0, 12'h030, 32'h11111111, 4'hF, 3'b001, 1'b0);
      @(posedge PCLK); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h030;
      pwdata = 32'h55555555; pwstrb = 4'hF;
      @(posedge PCLK); #1;
      penable = 1'b1; PRESET = 1'b1;
      rd(0, 12'h030, 3'b001, 32'h11111111, 1'b0);

`ifdef APBSLAVE_PRIV_EN
      wr(0, 12'h200, 32'h2468ACE0, 4'hF, 3'b001, 1'b0);
      wr(0, 12'h200, 32'h13579BDF, 4'hF, 3'b000, 1'b1);
      rd(0, 12'h200, 3'b001, 32'h2468ACE0, 1'b0);
      rd(0, 12'h200, 3'b000, 32'h00000000, 1'b1);
      wr(0, 12'h200, 32'h13579BDF, 4'hF, 3'b001, 1'b0);
      rd(0, 12'h200, 3'b001, 32'h13579BDF, 1'b0);
`else
      wr(0, 12'h200, 32'h13579BDF, 4'hF, 3'b000, 1'b0);
      rd(0, 12'h200, 3'b000, 32'h13579BDF, 1'b0);
`endif
      idle();

      // second DUT: write waits 3, read waits 2, low-power PRDATA
      wr(1, 12'h020, 32'h0BADF00D, 4'hF, 3'b001, 1'b0);
      rd(1, 12'h020, 3'b001, 32'h0BADF00D, 1'b0);
      idle();
      @(negedge PCLK);
      chk("lowpower_prdata1", if1.PRDATA, 32'h0);
      xfer(1, 1'b1, 12'h020, 32'hDEADBEEF, 4'hF, 3'b001, 2);
      rd(1, 12'h020, 3'b001, 32'h0BADF00D, 1'b0);
      rd(1, 12'h400, 3'b001, 32'h00000000, 1'b1);
      idle();

      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      chk("pending_rsp0", q0.size(), 32'h0);
      chk("pending_rsp1", q1.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
